npn_eval_sequencer: RTL
=======================

Name: npn_eval_sequencer

Overview:
Sequencer that drives one shared 4-input combinational function unit (an exact AIG netlist under test) through all 16 minterms. Inputs pass through a requested NPN transform: input permutation, input negation and output negation. The block assembles the resulting 16-bit truth table, compares it with an expected table and returns the result over a valid/ready response channel. It sits between the NPN-class test harness and the AIG instance being characterised.

Parameters:
EVAL_LAT, 1, cycles each minterm is held on fn_x before fn_y is sampled (legal range 1..15)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_perm  input  8  field [2i+1:2i] = minterm bit index that drives fn_x[i]; identity = 8'hE4
req_neg_in  input  4  per-input negation mask, applied after permutation
req_neg_out  input  1  invert fn_y before capture
req_expect  input  16  expected truth table, bit m = result for minterm m
fn_x  output  4  inputs to the shared function unit (registered)
fn_y  input  1  output of the function unit
busy  output  1  high in SWEEP or RESP
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed
rsp_tt  output  16  captured, transformed truth table
rsp_match  output  1  rsp_tt == latched expect, and no perm error
rsp_perm_err  output  1  req_perm was not a bijection; no sweep performed

Behaviour:
- Reset values (async, rst_n low): state=IDLE, fn_x=0, rsp_valid=0, rsp_tt=0, rsp_match=0, rsp_perm_err=0, busy=0, internal minterm/wait counters=0, latched config=0.
- Request acceptance: on req_valid&&req_ready, latch perm, neg_in, neg_out and expect. Cleared tt accumulator.
- IDLE: req_ready=1. On accept, if the perm is invalid (any index repeated) go to RESP with rsp_tt=0, rsp_match=0, rsp_perm_err=1. Otherwise set minterm m=0 and wait=0, load fn_x with the transform of m=0, and go to SWEEP.
- Transform: fn_x[i] = m[perm[i]] ^ neg_in[i]. Capture: tt[m] = fn_y ^ neg_out.
- SWEEP: fn_x holds the transform of m for exactly EVAL_LAT cycles. fn_y is sampled on the edge that ends the EVAL_LAT-th cycle. On that edge, write tt[m], then either increment m and reload fn_x, or, if m==15, go to RESP.
- Sweep length: exactly 16*EVAL_LAT cycles. The m counter is 4 bits and wraps only on the transition to RESP.
- RESP: rsp_valid=1. rsp_tt, rsp_match and rsp_perm_err are stable while rsp_valid&&!rsp_ready. fn_x returns to 0 on entry.
- Leaving RESP: on rsp_valid&&rsp_ready go to IDLE. req_ready rises in the following cycle, so there is no same-cycle re-accept.
- Latency: accept edge to rsp_valid high = 16*EVAL_LAT+1 cycles for a valid perm, 1 cycle for a perm error.
- req_valid outside IDLE is ignored and not queued. Request inputs may change freely after acceptance.
- busy = (state != IDLE).
- rsp_match compares all 16 bits. There is no partial-compare mode.
- Reset asserted mid-sweep or mid-response: immediate return to the reset values. No response is emitted for the aborted request.
- fn_y is assumed combinationally settled within EVAL_LAT cycles. The block performs no synchronisation.

Decomposition:
- Shared package npn_pkg holds:
  - typedefs perm_t (logic[7:0]), tt_t (logic[15:0]), minterm_t (logic[3:0]);
  - enum state_t {IDLE, SWEEP, RESP};
  - constant IDENTITY_PERM=8'hE4;
  - function perm_is_bijection(perm_t).
- One natural sub-module, npn_perm_apply: purely combinational, (minterm, perm, neg_in) -> 4-bit vector. It is reused by the harness's golden model.
- The FSM, counters and capture register stay in npn_eval_sequencer.

Test Plan:
- AND4 stub, perm=E4, neg_in=0, neg_out=0, expect=16'h8000, EVAL_LAT=1 -> rsp_valid 17 cycles after accept, rsp_tt=8000, rsp_match=1.
- Same stub, neg_in=4'hF -> rsp_tt=16'h0001. Also with neg_out=1 and expect=8000 -> rsp_tt=16'hFFFE, rsp_match=0.
- Stub y=x0, perm=8'h1B (fn_x[0]<-m[3]) -> rsp_tt=16'hFF00. Check fn_x sequence 0,8,4,C,... per minterm.
- req_perm=8'h00 -> rsp_perm_err=1, rsp_tt=0, rsp_match=0, rsp_valid one cycle after accept, fn_x never leaves 0.
- EVAL_LAT=3, rsp_ready held low 5 cycles -> each fn_x value held 3 cycles, rsp_valid 49 cycles after accept, outputs stable during stall, req_ready=0 and a second req_valid ignored until the cycle after the handshake.
- rst_n pulsed low at minterm 7 -> all outputs return to reset values asynchronously. The next request completes normally with a correct table.

Source files
------------

// File: rtl/npn_pkg.sv
// Shared types and helpers for the NPN evaluation sequencer and its harness.
package npn_pkg;

  typedef logic [7:0]  perm_t;
  typedef logic [15:0] tt_t;
  typedef logic [3:0]  minterm_t;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    RESP
  } state_t;

  localparam perm_t IDENTITY_PERM = 8'hE4;

  // A permutation is legal only when the four 2-bit source indices are all distinct.
  function automatic logic perm_is_bijection(perm_t perm);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        if (perm[2*i +: 2] == perm[2*j +: 2]) begin
          ok = 1'b0;
        end
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/npn_eval_sequencer_if.sv
// Request/response channels between the NPN-class harness and the sequencer.
interface npn_eval_sequencer_if;
  import npn_pkg::*;

  logic        req_valid;
  logic        req_ready;
  perm_t       req_perm;
  logic [3:0]  req_neg_in;
  logic        req_neg_out;
  tt_t         req_expect;

  logic        rsp_valid;
  logic        rsp_ready;
  tt_t         rsp_tt;
  logic        rsp_match;
  logic        rsp_perm_err;

  // Harness side: issues requests, consumes responses.
  modport master (
    output req_valid, req_perm, req_neg_in, req_neg_out, req_expect, rsp_ready,
    input  req_ready, rsp_valid, rsp_tt, rsp_match, rsp_perm_err
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_perm, req_neg_in, req_neg_out, req_expect, rsp_ready,
    output req_ready, rsp_valid, rsp_tt, rsp_match, rsp_perm_err
  );

endinterface

// File: rtl/npn_perm_apply.sv
// Combinational NPN input transform: x[i] = minterm[perm[i]] ^ neg_in[i].
module npn_perm_apply
  import npn_pkg::*;
(
  input  minterm_t   minterm_i,
  input  perm_t      perm_i,
  input  logic [3:0] neg_in_i,
  output logic [3:0] x_o
);

  // Each function-unit input picks one minterm bit, then optionally inverts it.
  for (genvar gi = 0; gi < 4; gi++) begin : g_bit
    assign x_o[gi] = minterm_i[perm_i[2*gi +: 2]] ^ neg_in_i[gi];
  end

endmodule

// File: rtl/npn_eval_sequencer.sv
// Sweeps a shared 4-input function unit over all minterms under an NPN
// transform, builds the truth table and reports it against an expected table.
module npn_eval_sequencer
  import npn_pkg::*;
#(
  parameter int EVAL_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  npn_eval_sequencer_if.slave         bus,
  output logic [3:0]                  fn_x,
  input  logic                        fn_y,
  output logic                        busy
);

  localparam logic [3:0] WAIT_LAST = 4'(EVAL_LAT - 1);

  state_t     state_q, state_d;
  minterm_t   m_q, m_d;
  logic [3:0] wait_q, wait_d;
  perm_t      perm_q, perm_d;
  logic [3:0] neg_in_q, neg_in_d;
  logic       neg_out_q, neg_out_d;
  tt_t        expect_q, expect_d;
  tt_t        tt_q, tt_d;
  logic [3:0] fn_x_q, fn_x_d;
  tt_t        rsp_tt_q, rsp_tt_d;
  logic       rsp_match_q, rsp_match_d;
  logic       rsp_perm_err_q, rsp_perm_err_d;

  // Shared transform: in IDLE it prepares minterm 0 from the live request,
  // during SWEEP it prepares the next minterm from the latched configuration.
  minterm_t   xf_m;
  perm_t      xf_perm;
  logic [3:0] xf_neg_in;
  logic [3:0] xf_x;

  assign xf_m      = (state_q == IDLE) ? minterm_t'(0) : minterm_t'(m_q + 4'd1);
  assign xf_perm   = (state_q == IDLE) ? bus.req_perm   : perm_q;
  assign xf_neg_in = (state_q == IDLE) ? bus.req_neg_in : neg_in_q;

  npn_perm_apply u_perm_apply (
    .minterm_i (xf_m),
    .perm_i    (xf_perm),
    .neg_in_i  (xf_neg_in),
    .x_o       (xf_x)
  );

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.rsp_tt       = rsp_tt_q;
  assign bus.rsp_match    = rsp_match_q;
  assign bus.rsp_perm_err = rsp_perm_err_q;
  assign busy             = (state_q != IDLE);
  assign fn_x             = fn_x_q;

  // State, counters, latched request and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      m_q            <= '0;
      wait_q         <= '0;
      perm_q         <= '0;
      neg_in_q       <= '0;
      neg_out_q      <= 1'b0;
      expect_q       <= '0;
      tt_q           <= '0;
      fn_x_q         <= '0;
      rsp_tt_q       <= '0;
      rsp_match_q    <= 1'b0;
      rsp_perm_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      m_q            <= m_d;
      wait_q         <= wait_d;
      perm_q         <= perm_d;
      neg_in_q       <= neg_in_d;
      neg_out_q      <= neg_out_d;
      expect_q       <= expect_d;
      tt_q           <= tt_d;
      fn_x_q         <= fn_x_d;
      rsp_tt_q       <= rsp_tt_d;
      rsp_match_q    <= rsp_match_d;
      rsp_perm_err_q <= rsp_perm_err_d;
    end
  end

  // Next-state logic: accept, per-minterm hold/sample, response handshake.
  always_comb begin
    tt_t tt_cap;

    state_d        = state_q;
    m_d            = m_q;
    wait_d         = wait_q;
    perm_d         = perm_q;
    neg_in_d       = neg_in_q;
    neg_out_d      = neg_out_q;
    expect_d       = expect_q;
    tt_d           = tt_q;
    fn_x_d         = fn_x_q;
    rsp_tt_d       = rsp_tt_q;
    rsp_match_d    = rsp_match_q;
    rsp_perm_err_d = rsp_perm_err_q;

    tt_cap         = tt_q;
    tt_cap[m_q]    = fn_y ^ neg_out_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          perm_d    = bus.req_perm;
          neg_in_d  = bus.req_neg_in;
          neg_out_d = bus.req_neg_out;
          expect_d  = bus.req_expect;
          tt_d      = '0;
          m_d       = '0;
          wait_d    = '0;
          if (!perm_is_bijection(bus.req_perm)) begin
            // Illegal permutation: answer immediately without touching fn_x.
            state_d        = RESP;
            fn_x_d         = '0;
            rsp_tt_d       = '0;
            rsp_match_d    = 1'b0;
            rsp_perm_err_d = 1'b1;
          end else begin
            state_d = SWEEP;
            fn_x_d  = xf_x;
          end
        end
      end

      SWEEP: begin
        if (wait_q == WAIT_LAST) begin
          // fn_y has been stable for EVAL_LAT cycles: capture this minterm.
          tt_d   = tt_cap;
          wait_d = '0;
          if (m_q == 4'd15) begin
            state_d        = RESP;
            m_d            = '0;
            fn_x_d         = '0;
            rsp_tt_d       = tt_cap;
            rsp_match_d    = (tt_cap == expect_q);
            rsp_perm_err_d = 1'b0;
          end else begin
            m_d    = minterm_t'(m_q + 4'd1);
            fn_x_d = xf_x;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
